// File: rtl/psg_bus_writer.sv
// psg_bus_writer: expands whole-register commands into the sound chip's
// nibble-serial write bus (address write A0=0, data write A0=1).
// Each bus write is SETUP (1) -> STROBE (WR_CYCLES) -> HOLD (1).
// Optional macro PSG_BUS_WRITER_DELTA_EN: skip pairs whose nibble already
// matches a shadow copy of the last value written to that chip register.
module psg_bus_writer #(
  parameter int unsigned WR_CYCLES  = 1,
  parameter int unsigned GAP_CYCLES = 0
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        CMD_VALID,
  output logic        CMD_READY,
  input  logic        CMD_KIND,
  input  logic [1:0]  CMD_CHAN,
  input  logic [11:0] CMD_DATA,
  output logic        CMD_ERR,
  output logic        BUSY,
  output logic        WR,
  output logic        A0,
  output logic [3:0]  D
);

  localparam int unsigned DW = 12;
  localparam int unsigned NW = 4;
  localparam int unsigned TW = 4;
  localparam int unsigned CW = 2;

  typedef enum logic [3:0] {
    S_IDLE, S_ADDR_SETUP, S_ADDR_STROBE, S_ADDR_HOLD,
    S_DATA_SETUP, S_DATA_STROBE, S_DATA_HOLD, S_GAP, S_DONE
  } state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [TW-1:0] timer, timer_n;
  logic          kind_q, kind_n;
  logic [1:0]    chan_q, chan_n;
  logic [DW-1:0] data_q, data_n;
  logic          err_q, err_n;
  logic          ready_n, busy_n, cmd_err_n, wr_n, a0_n;
  logic [NW-1:0] d_n;

  logic          src_kind;
  logic [1:0]    src_chan;
  logic [DW-1:0] src_data;
  logic [2:0]    from_idx;
  logic [2:0]    dirty;
  logic          found;
  logic [CW-1:0] pick;

  function automatic logic [3:0] nib_of(input logic k, input logic [11:0] dt, input logic [1:0] n);
    if (k) return {1'b0, dt[2:0]};
    case (n)
      2'd0:    return dt[3:0];
      2'd1:    return dt[7:4];
      default: return dt[11:8];
    endcase
  endfunction

  function automatic logic [3:0] addr_of(input logic k, input logic [1:0] c, input logic [1:0] n);
    if (k) return 4'd15;
    return 4'(4'(c) * 4'd3 + 4'(n) + 4'd1);
  endfunction

  // Command source: live inputs while idle (accept edge), held copy afterwards
  assign src_kind = (state == S_IDLE) ? CMD_KIND : kind_q;
  assign src_chan = (state == S_IDLE) ? CMD_CHAN : chan_q;
  assign src_data = (state == S_IDLE) ? CMD_DATA : data_q;
  assign from_idx = (state == S_IDLE) ? 3'd0 : ({1'b0, cnt} + 3'd1);

`ifdef PSG_BUS_WRITER_DELTA_EN
  localparam int unsigned SHN = 10;

  logic [SHN-1:0] sh_valid;
  logic [NW-1:0]  sh_nib [SHN];
  logic [3:0]     slot;

  function automatic logic [3:0] slot_of(input logic k, input logic [1:0] c, input logic [1:0] n);
    if (k) return 4'd9;
    return 4'(4'(c) * 4'd3 + 4'(n));
  endfunction

  // Nibbles of the source command that differ from (or are missing in) the shadow
  always_comb begin
    dirty = '0;
    slot  = '0;
    for (int i = 0; i < 3; i++) begin
      slot = slot_of(src_kind, src_chan, 2'(i));
      if ((!src_kind || i == 0) && slot < 4'(SHN))
        dirty[i] = !sh_valid[slot] || (sh_nib[slot] != nib_of(src_kind, src_data, 2'(i)));
    end
  end

  // Shadow update when a data write completes; RST invalidates everything
  always_ff @(posedge CLK) begin
    if (RST) begin
      sh_valid <= '0;
    end else if (state == S_DATA_HOLD) begin
      sh_valid[slot_of(kind_q, chan_q, cnt)] <= 1'b1;
      sh_nib[slot_of(kind_q, chan_q, cnt)]   <= nib_of(kind_q, data_q, cnt);
    end
  end
`else
  // Every nibble of the command is written
  always_comb dirty = src_kind ? 3'b001 : 3'b111;
`endif

  // First nibble at or after from_idx that needs a bus write
  always_comb begin
    found = 1'b0;
    pick  = '0;
    for (int i = 2; i >= 0; i--) begin
      if (dirty[i] && 3'(i) >= from_idx) begin
        found = 1'b1;
        pick  = CW'(i);
      end
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    timer_n = timer;
    kind_n  = kind_q;
    chan_n  = chan_q;
    data_n  = data_q;
    err_n   = err_q;
    case (state)
      S_IDLE: begin
        if (CMD_VALID && CMD_READY) begin
          kind_n = CMD_KIND;
          chan_n = CMD_CHAN;
          data_n = CMD_DATA;
          cnt_n  = '0;
          err_n  = !CMD_KIND && (CMD_CHAN == 2'd3);
          if (!err_n && found) begin
            state_n = S_ADDR_SETUP;
            cnt_n   = pick;
          end else begin
            state_n = S_DONE;
          end
        end
      end
      S_ADDR_SETUP: begin
        state_n = S_ADDR_STROBE;
        timer_n = TW'(WR_CYCLES - 1);
      end
      S_ADDR_STROBE: begin
        if (timer == '0) state_n = S_ADDR_HOLD;
        else             timer_n = timer - TW'(1);
      end
      S_ADDR_HOLD: state_n = S_DATA_SETUP;
      S_DATA_SETUP: begin
        state_n = S_DATA_STROBE;
        timer_n = TW'(WR_CYCLES - 1);
      end
      S_DATA_STROBE: begin
        if (timer == '0) state_n = S_DATA_HOLD;
        else             timer_n = timer - TW'(1);
      end
      S_DATA_HOLD: begin
        if (found) begin
          state_n = S_ADDR_SETUP;
          cnt_n   = pick;
        end else if (GAP_CYCLES != 0) begin
          state_n = S_GAP;
          timer_n = TW'(GAP_CYCLES - 1);
        end else begin
          state_n = S_IDLE;
        end
      end
      S_GAP: begin
        if (timer == '0) state_n = S_IDLE;
        else             timer_n = timer - TW'(1);
      end
      S_DONE: begin
        if (err_q || GAP_CYCLES == 0) begin
          state_n = S_IDLE;
        end else begin
          state_n = S_GAP;
          timer_n = TW'(GAP_CYCLES - 1);
        end
      end
      default: state_n = S_IDLE;
    endcase

    ready_n   = (state_n == S_IDLE);
    busy_n    = (state_n != S_IDLE);
    cmd_err_n = (state_n == S_DONE) && err_n;
    wr_n      = (state_n == S_ADDR_STROBE) || (state_n == S_DATA_STROBE);
    a0_n      = A0;
    d_n       = D;
    if (state_n == S_ADDR_SETUP) begin
      a0_n = 1'b0;
      d_n  = addr_of(src_kind, src_chan, cnt_n);
    end else if (state_n == S_DATA_SETUP) begin
      a0_n = 1'b1;
      d_n  = nib_of(kind_q, data_q, cnt);
    end
  end

  // State, holding registers and registered outputs
  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= S_IDLE;
      cnt       <= '0;
      timer     <= '0;
      kind_q    <= 1'b0;
      chan_q    <= '0;
      data_q    <= '0;
      err_q     <= 1'b0;
      CMD_READY <= 1'b0;
      BUSY      <= 1'b0;
      CMD_ERR   <= 1'b0;
      WR        <= 1'b0;
      A0        <= 1'b0;
      D         <= '0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      timer     <= timer_n;
      kind_q    <= kind_n;
      chan_q    <= chan_n;
      data_q    <= data_n;
      err_q     <= err_n;
      CMD_READY <= ready_n;
      BUSY      <= busy_n;
      CMD_ERR   <= cmd_err_n;
      WR        <= wr_n;
      A0        <= a0_n;
      D         <= d_n;
    end
  end

endmodule

// File: tb/tb_psg_bus_writer.sv
// Bench for psg_bus_writer: two instances (default timing and WR=3/GAP=2),
// a per-cycle expected-trace model built from the bus protocol rules, and
// directed literal checks plus randomized command streams.
module tb_psg_bus_writer;

  localparam int unsigned W0 = 1, G0 = 0, W1 = 3, G1 = 2;
  localparam int unsigned TL = 64;

  typedef struct packed {
    logic       ready;
    logic       busy;
    logic       err;
    logic       wr;
    logic       a0;
    logic [3:0] d;
  } obs_t;

  logic clk = 1'b0;
  logic rst [2];
  logic valid [2];
  logic kind [2];
  logic [1:0] chan [2];
  logic [11:0] data [2];
  logic ready [2];
  logic err [2];
  logic busy [2];
  logic wr [2];
  logic a0 [2];
  logic [3:0] d [2];

  int errors = 0;
  int checks = 0;

  obs_t exp_tr [2][TL];
  int exp_len [2];
  int exp_pos [2];
  logic cur_a0 [2];
  logic [3:0] cur_d [2];
  bit rst_seen [2];
`ifdef PSG_BUS_WRITER_DELTA_EN
  bit sh_v [2][10];
  logic [3:0] sh_n [2][10];
`endif

  logic [4:0] wlog [2][16];
  int wcnt [2];
  int whigh [2];
  int errcnt [2];
  logic prev_wr [2];

  always #5 clk = ~clk;

  psg_bus_writer #(.WR_CYCLES(W0), .GAP_CYCLES(G0)) dut0 (
    .CLK(clk), .RST(rst[0]), .CMD_VALID(valid[0]), .CMD_READY(ready[0]),
    .CMD_KIND(kind[0]), .CMD_CHAN(chan[0]), .CMD_DATA(data[0]), .CMD_ERR(err[0]),
    .BUSY(busy[0]), .WR(wr[0]), .A0(a0[0]), .D(d[0]));

  psg_bus_writer #(.WR_CYCLES(W1), .GAP_CYCLES(G1)) dut1 (
    .CLK(clk), .RST(rst[1]), .CMD_VALID(valid[1]), .CMD_READY(ready[1]),
    .CMD_KIND(kind[1]), .CMD_CHAN(chan[1]), .CMD_DATA(data[1]), .CMD_ERR(err[1]),
    .BUSY(busy[1]), .WR(wr[1]), .A0(a0[1]), .D(d[1]));

  function automatic obs_t mk(logic r, logic b, logic e, logic w, logic a, logic [3:0] v);
    obs_t o;
    o.ready = r; o.busy = b; o.err = e; o.wr = w; o.a0 = a; o.d = v;
    return o;
  endfunction

  function automatic void push(int u, obs_t o);
    if (exp_len[u] < int'(TL)) exp_tr[u][exp_len[u]] = o;
    exp_len[u]++;
  endfunction

  // One bus write: setup, w strobe cycles, hold
  function automatic void bus_unit(int u, logic a, logic [3:0] v, int w);
    cur_a0[u] = a;
    cur_d[u]  = v;
    push(u, mk(1'b0, 1'b1, 1'b0, 1'b0, a, v));
    for (int i = 0; i < w; i++) push(u, mk(1'b0, 1'b1, 1'b0, 1'b1, a, v));
    push(u, mk(1'b0, 1'b1, 1'b0, 1'b0, a, v));
  endfunction

  // Expected output trace for cycles 1.. after an accept edge
  function automatic void model_cmd(int u, logic k, logic [1:0] c, logic [11:0] dt);
    int w, g, wrote;
    w = (u == 0) ? int'(W0) : int'(W1);
    g = (u == 0) ? int'(G0) : int'(G1);
    wrote = 0;
    exp_len[u] = 0;
    exp_pos[u] = 0;
    if (!k && c == 2'd3) begin
      push(u, mk(1'b0, 1'b1, 1'b1, 1'b0, cur_a0[u], cur_d[u]));
      return;
    end
    for (int n = 0; n < (k ? 1 : 3); n++) begin
      logic [3:0] ad, dv;
      ad = k ? 4'hF : 4'(int'(c) * 3 + n + 1);
      dv = k ? {1'b0, dt[2:0]} : dt[4*n +: 4];
`ifdef PSG_BUS_WRITER_DELTA_EN
      begin
        int slot;
        slot = k ? 9 : int'(c) * 3 + n;
        if (sh_v[u][slot] && sh_n[u][slot] == dv) continue;
        sh_v[u][slot] = 1'b1;
        sh_n[u][slot] = dv;
      end
`endif
      bus_unit(u, 1'b0, ad, w);
      bus_unit(u, 1'b1, dv, w);
      wrote++;
    end
    if (wrote == 0) push(u, mk(1'b0, 1'b1, 1'b0, 1'b0, cur_a0[u], cur_d[u]));
    for (int i = 0; i < g; i++) push(u, mk(1'b0, 1'b1, 1'b0, 1'b0, cur_a0[u], cur_d[u]));
  endfunction

  // Reset bookkeeping on each active edge
  always @(posedge clk) begin
    for (int u = 0; u < 2; u++) begin
      rst_seen[u] = rst[u];
      if (rst[u]) begin
        exp_len[u] = 0;
        exp_pos[u] = 0;
        cur_a0[u]  = 1'b0;
        cur_d[u]   = 4'h0;
`ifdef PSG_BUS_WRITER_DELTA_EN
        for (int s = 0; s < 10; s++) sh_v[u][s] = 1'b0;
`endif
      end
    end
  end

  // Per-cycle compare against the model, plus bus-write logging
  always @(negedge clk) begin
    for (int u = 0; u < 2; u++) begin
      obs_t e, a;
      a = mk(ready[u], busy[u], err[u], wr[u], a0[u], d[u]);
      if (rst_seen[u]) e = '0;
      else if (exp_pos[u] < exp_len[u]) begin
        e = exp_tr[u][exp_pos[u]];
        exp_pos[u]++;
      end else e = mk(1'b1, 1'b0, 1'b0, 1'b0, cur_a0[u], cur_d[u]);
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL dut%0d outputs at %0t: got rdy/busy/err/wr/a0/d=%b required %b", u, $time, a, e);
      end
      if (a.wr === 1'b1 && prev_wr[u] !== 1'b1) begin
        if (wcnt[u] < 16) wlog[u][wcnt[u]] = {a.a0, a.d};
        wcnt[u]++;
      end
      if (a.wr === 1'b1) whigh[u]++;
      if (a.err === 1'b1) errcnt[u]++;
      prev_wr[u] = a.wr;
    end
  end

  task automatic check(string nm, int act, int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d required %0d", nm, act, req);
    end
  endtask

  task automatic check_log(int u, string nm, int n, logic [39:0] ex);
    check({nm, " write count"}, wcnt[u], n);
    for (int i = 0; i < n && i < 8 && i < wcnt[u]; i++)
      check($sformatf("%s write %0d", nm, i), int'(wlog[u][i]), int'(ex[39-5*i -: 5]));
  endtask

  task automatic clear_log(int u);
    wcnt[u] = 0;
    whigh[u] = 0;
    errcnt[u] = 0;
  endtask

  // Offer a command (call at a negedge); returns at the negedge of cycle 1
  task automatic send(int u, logic k, logic [1:0] c, logic [11:0] dt, bit hold);
    int n;
    n = 0;
    kind[u] = k; chan[u] = c; data[u] = dt; valid[u] = 1'b1;
    while (ready[u] !== 1'b1) begin
      @(negedge clk);
      n++;
      if (n > 200) begin
        checks++;
        errors++;
        $display("FAIL dut%0d accept timeout: got ready=%b required 1", u, ready[u]);
        valid[u] = 1'b0;
        return;
      end
    end
    @(posedge clk);
    model_cmd(u, k, c, dt);
    @(negedge clk);
    if (!hold) valid[u] = 1'b0;
    kind[u] = 1'($urandom); chan[u] = 2'($urandom); data[u] = 12'($urandom);
  endtask

  task automatic wait_ready(int u, output int lat);
    lat = 1;
    while (ready[u] !== 1'b1) begin
      @(negedge clk);
      lat++;
      if (lat > 200) return;
    end
  endtask

  task automatic pulse_rst(int u);
    rst[u] = 1'b1;
    @(negedge clk);
    rst[u] = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    for (int u = 0; u < 2; u++) begin
      rst[u] = 1'b1; valid[u] = 1'b0; kind[u] = 1'b0; chan[u] = '0; data[u] = '0;
      wcnt[u] = 0; whigh[u] = 0; errcnt[u] = 0; prev_wr[u] = 1'b0;
      exp_len[u] = 0; exp_pos[u] = 0; cur_a0[u] = 1'b0; cur_d[u] = '0;
    end
    @(negedge clk);
    check("reset ready", int'(ready[0]), 0);
    check("reset busy", int'(busy[0]), 0);
    check("reset wr/a0/d", int'({wr[0], a0[0], d[0]}), 0);
    repeat (2) @(negedge clk);
    rst[0] = 1'b0; rst[1] = 1'b0;
    @(negedge clk);
    check("ready after reset", int'(ready[0]), 1);

    // Frequency write, default timing
    clear_log(0);
    send(0, 1'b0, 2'd0, 12'hA5C, 1'b0);
    wait_ready(0, lat);
    check("a5c latency", lat, 19);
    check_log(0, "a5c", 6, {5'h01, 5'h1C, 5'h02, 5'h15, 5'h03, 5'h1A, 10'h0});
    check("a5c wr cycles", whigh[0], 6);

    // Triangle then control, WR=3 GAP=2
    clear_log(1);
    send(1, 1'b0, 2'd2, 12'h123, 1'b0);
    wait_ready(1, lat);
    check("tri latency", lat, 33);
    check_log(1, "tri", 6, {5'h07, 5'h13, 5'h08, 5'h12, 5'h09, 5'h11, 10'h0});
    check("tri wr cycles", whigh[1], 18);
    clear_log(1);
    send(1, 1'b1, 2'd0, 12'h005, 1'b0);
    wait_ready(1, lat);
    check("ctl latency", lat, 13);
    check_log(1, "ctl", 2, {5'h0F, 5'h15, 30'h0});

    // Back-to-back with VALID held high
    clear_log(0);
    send(0, 1'b1, 2'd1, 12'h006, 1'b1);
    send(0, 1'b0, 2'd1, 12'h321, 1'b0);
    wait_ready(0, lat);
    check("b2b second latency", lat, 19);
    check_log(0, "b2b", 8, {5'h0F, 5'h16, 5'h04, 5'h11, 5'h05, 5'h12, 5'h06, 5'h13});

    // Reserved channel on both timings
    for (int u = 0; u < 2; u++) begin
      clear_log(u);
      send(u, 1'b0, 2'd3, 12'hFFF, 1'b0);
      wait_ready(u, lat);
      check($sformatf("rsv%0d latency", u), lat, 2);
      check($sformatf("rsv%0d err pulses", u), errcnt[u], 1);
      check($sformatf("rsv%0d writes", u), wcnt[u], 0);
    end

    // Reset during the second data strobe
    send(0, 1'b0, 2'd0, 12'h5A5, 1'b0);
    repeat (10) @(negedge clk);
    check("mid strobe wr", int'(wr[0]), 1);
    check("mid strobe a0", int'(a0[0]), 1);
    rst[0] = 1'b1;
    @(negedge clk);
    rst[0] = 1'b0;
    check("mid reset outputs", int'({ready[0], busy[0], err[0], wr[0], a0[0], d[0]}), 0);
    @(negedge clk);
    check("mid reset ready after", int'(ready[0]), 1);

    // Tone B rewrites (delta skipping when enabled)
    pulse_rst(0);
    clear_log(0);
    send(0, 1'b0, 2'd1, 12'h777, 1'b0);
    wait_ready(0, lat);
    check("d777 writes", wcnt[0], 6);
    clear_log(0);
    send(0, 1'b0, 2'd1, 12'h7A7, 1'b0);
    wait_ready(0, lat);
`ifdef PSG_BUS_WRITER_DELTA_EN
    check_log(0, "d7a7", 2, {5'h05, 5'h1A, 30'h0});
    check("d7a7 latency", lat, 7);
`else
    check("d7a7 writes", wcnt[0], 6);
    check("d7a7 latency", lat, 19);
`endif
    clear_log(0);
    send(0, 1'b0, 2'd1, 12'h7A7, 1'b0);
    wait_ready(0, lat);
`ifdef PSG_BUS_WRITER_DELTA_EN
    check("repeat writes", wcnt[0], 0);
    check("repeat latency", lat, 2);
`else
    check("repeat writes", wcnt[0], 6);
    check("repeat latency", lat, 19);
`endif
    pulse_rst(0);
    clear_log(0);
    send(0, 1'b0, 2'd1, 12'h7A7, 1'b0);
    wait_ready(0, lat);
    check("post reset writes", wcnt[0], 6);
    check("post reset latency", lat, 19);

    // Randomized command streams
    for (int u = 0; u < 2; u++) begin
      for (int it = 0; it < 40; it++) begin
        logic k;
        logic [1:0] c;
        logic [11:0] dt;
        bit hold;
        k = ($urandom_range(0, 3) == 0);
        c = 2'($urandom_range(0, 3));
        case ($urandom_range(0, 3))
          0:       dt = 12'h777;
          1:       dt = 12'h7A7;
          2:       dt = {8'h77, 4'($urandom_range(0, 15))};
          default: dt = 12'($urandom);
        endcase
        hold = (it != 39) && ($urandom_range(0, 1) == 1);
        send(u, k, c, dt, hold);
        if (!hold) repeat ($urandom_range(0, 3)) @(negedge clk);
      end
      valid[u] = 1'b0;
      wait_ready(u, lat);
      check($sformatf("random stream %0d drains", u), int'(ready[u]), 1);
    end
    repeat (5) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/psg_bus_writer.md
Name: psg_bus_writer

Overview:
- Host-side master for the sound chip's 4-bit register-write bus (WR, A0, D[3:0]).
- Takes whole-register commands from a valid/ready interface: a 12-bit frequency divider for one of three generators, or a 3-bit mixer/control value.
- Expands each command into the nibble-serial sequence of address writes (A0=0) and data writes (A0=1) that the chip decodes.
- Sits in the host/test-harness side of the design and drives the chip pins directly.

Parameters:
- WR_CYCLES, 1, width of each WR strobe in CLK cycles (1..15).
- GAP_CYCLES, 0, idle cycles inserted after the last bus write of a command, before CMD_READY returns (0..15).

Ports:
- CLK  in  1  single clock; also the chip's CLK.
- RST  in  1  synchronous reset, active-high.
- CMD_VALID  in  1  command offered.
- CMD_READY  out  1  writer idle and able to accept a command.
- CMD_KIND  in  1  0 = frequency write, 1 = control write.
- CMD_CHAN  in  2  0 = tone A, 1 = tone B, 2 = triangle, 3 = reserved.
- CMD_DATA  in  12  divider (KIND=0) or control bits [2:0] (KIND=1).
- CMD_ERR  out  1  one-cycle pulse when a KIND=0, CHAN=3 command is accepted and dropped.
- BUSY  out  1  high from the accept edge until return to IDLE.
- WR  out  1  chip write strobe.
- A0  out  1  0 = address nibble, 1 = data nibble.
- D  out  4  chip data nibble.

Behaviour:
Interface decision:
- One clock (CLK); reset RST is synchronous and active-high.

Reset:
- While RST=1, state = IDLE and all outputs are 0, including CMD_READY, WR, A0, D, BUSY and CMD_ERR.
- All outputs are registered.

Handshake:
- CMD_READY=1 only in IDLE with RST=0.
- Accept occurs on an edge where CMD_VALID & CMD_READY; CMD_* is captured into holding registers at that edge.
- CMD_* inputs are don't-care at all other times.

Address map:
- Tone A: L=1, H=2, HH=3.
- Tone B: L=4, H=5, HH=6.
- Triangle: L=7, H=8, HH=9.
- Control: 15.
- Nibble order for a frequency command is L=DATA[3:0], then H=DATA[7:4], then HH=DATA[11:8].
- Control data nibble = {1'b0, DATA[2:0]}.

Bus write unit, SETUP -> STROBE -> HOLD:
- SETUP: 1 cycle, A0/D valid, WR=0.
- STROBE: WR_CYCLES cycles, WR=1.
- HOLD: 1 cycle, WR=0, A0/D unchanged.
- A0 and D change only on entry to SETUP; WR is never high while A0/D are changing.

Command sequences:
- A frequency command is 3 pairs of (address write, data write) = 6 units.
- A control command is 1 pair = 2 units.

FSM:
- IDLE -> (accept) ADDR_SETUP -> ADDR_STROBE -> ADDR_HOLD -> DATA_SETUP -> DATA_STROBE -> DATA_HOLD.
- From DATA_HOLD: go to the next pair if nibbles remain, else GAP (GAP_CYCLES cycles, skipped if 0) -> IDLE.
- A 2-bit nibble counter selects the nibble and address; it resets on accept.

Latency:
- With WR_CYCLES=W and GAP_CYCLES=G, the frequency bus activity occupies cycles 1..6(W+2) after the accept edge, and CMD_READY rises in cycle 6(W+2)+G+1.
- Control commands: 2(W+2)+G+1.
- Defaults: 19 cycles for frequency, 7 for control.

Reserved channel:
- KIND=0, CHAN=3: accepted, CMD_ERR pulses in cycle 1, no bus activity, return to IDLE in cycle 2.
- KIND=1 ignores CHAN.

Mid-operation reset:
- RST at any state forces WR=0 and IDLE at that edge; the partial register write is abandoned and the host must reissue.
- No other abort mechanism exists.

Optional Feature:
- Macro: PSG_BUS_WRITER_DELTA_EN.
- Enabled:
  - Keeps a shadow of the 9 frequency nibbles plus the control nibble, each with a valid bit; all valid bits are cleared by RST.
  - An address+data pair is issued only if its nibble is invalid or differs from the shadow. The shadow is updated and marked valid at DATA_HOLD.
  - Skipped pairs cost 0 cycles.
  - A command with no differing nibbles goes directly to GAP/IDLE, so CMD_READY returns in cycle 1+G+1.
- Disabled: no shadow logic; every nibble is always written.

Test Plan:
- Freq write, KIND=0, CHAN=0, DATA=0xA5C, defaults:
  - Bus (A0,D) sequence is (0,1)(1,C)(0,2)(1,5)(0,3)(1,A).
  - Each WR is high for exactly 1 cycle, with A0/D stable one cycle either side.
  - CMD_READY is high again in cycle 19.
- Triangle + control, WR_CYCLES=3, GAP_CYCLES=2:
  - CHAN=2, DATA=0x123 gives addresses 7,8,9 with data 3,2,1 and WR high for 3 cycles each; READY returns in cycle 33.
  - Then control DATA=0x005 gives (0,F)(1,5).
- Back-to-back: CMD_VALID held high with two commands. The second is accepted only on the cycle CMD_READY=1, and there is no WR glitch between commands.
- Reserved channel: KIND=0, CHAN=3 gives a CMD_ERR pulse of width 1, WR stays 0, and READY returns in cycle 2.
- Reset mid-command: assert RST during the second DATA_STROBE of a frequency write. WR=0 at the next edge, all outputs are 0, and CMD_READY=1 the cycle after RST deasserts.
- DELTA_EN, tone B writes:
  - First write 0x777: 6 units on the bus.
  - Then 0x7A7: only (0,5)(1,A).
  - Then 0x7A7 again: no bus activity, READY returns in cycle 2.
  - After an RST pulse, 0x7A7 is written in full.
